// File: rtl/tdc_event_arbiter.sv
// Round-robin merger of NCHAN TDC event streams into one tagged timestamp FIFO,
// drained by the CPU through a four-register CSR page with a level interrupt.
module tdc_event_arbiter #(
    parameter int         NCHAN      = 2,
    parameter int         TS_W       = 32,
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [3:0] CSR_ADDR   = 4'h2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [NCHAN-1:0]      ev_valid_i,
    input  logic [NCHAN-1:0]      ev_pol_i,
    input  logic [NCHAN*TS_W-1:0] ev_ts_i,
    output logic [NCHAN-1:0]      ev_ack_o,
    input  logic [13:0]           csr_a,
    input  logic                  csr_we,
    input  logic [31:0]           csr_di,
    output logic [31:0]           csr_do,
    output logic                  irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int ENT_W = 3 + 1 + TS_W;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    localparam logic [1:0]            REG_CTRL = 2'd0;
    localparam logic [1:0]            REG_STAT = 2'd1;
    localparam logic [1:0]            REG_META = 2'd2;
    localparam logic [1:0]            REG_TS   = 2'd3;
    localparam logic [2:0]            LAST_RST = 3'(NCHAN - 1);
    localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [NCHAN-1:0]      en_q, en_d;
    logic                  irq_en_q, irq_en_d;
    logic [2:0]            last_q, last_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            drop_q, drop_d;
    logic [31:0]           csr_do_q, csr_do_d;
    logic                  irq_q, irq_d;
    logic [ENT_W-1:0]      mem_q [DEPTH];

    logic                  page_sel;
    logic                  wr_ctrl, wr_stat, wr_pop;
    logic                  empty, full, pop;
    logic [NCHAN-1:0]      cand;
    logic [NCHAN-1:0]      gnt_oh;
    logic                  gnt_any;
    logic [2:0]            gnt_idx;
    logic                  pol_sel;
    logic [TS_W-1:0]       ts_sel;
    logic                  push_ok, drop;
    logic [ENT_W-1:0]      head;
    logic [31:0]           rdata;
    logic                  unused_ok;

    assign page_sel = (csr_a[13:10] == CSR_ADDR);
    assign wr_ctrl  = page_sel & csr_we & (csr_a[1:0] == REG_CTRL);
    assign wr_stat  = page_sel & csr_we & (csr_a[1:0] == REG_STAT);
    assign wr_pop   = page_sel & csr_we & (csr_a[1:0] == REG_TS);

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_FULL);
    assign pop   = wr_pop & ~empty;
    assign cand  = ev_valid_i & en_q;

    // Search starts one past the last grant and wraps modulo NCHAN.
    always_comb begin
        int c;
        logic [NCHAN-1:0] oh;
        gnt_any = 1'b0;
        gnt_idx = last_q;
        gnt_oh  = '0;
        c       = 0;
        oh      = '0;
        for (int off = 1; off <= NCHAN; off++) begin
            c  = (int'(last_q) + off) % NCHAN;
            oh = NCHAN'(1) << c;
            if (!gnt_any && |(cand & oh)) begin
                gnt_any = 1'b1;
                gnt_idx = 3'(c);
                gnt_oh  = oh;
            end
        end
    end

    // Disabled channels are acked every cycle so their streams drain unrecorded.
    assign ev_ack_o = gnt_oh | (ev_valid_i & ~en_q);

    assign pol_sel = |(ev_pol_i & gnt_oh);
    assign ts_sel  = TS_W'(ev_ts_i >> (TS_W * int'(gnt_idx)));

    assign push_ok = gnt_any & (~full | pop);
    assign drop    = gnt_any & ~push_ok;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        if (wr_ctrl) begin
            en_d     = csr_di[NCHAN-1:0];
            irq_en_d = csr_di[8];
        end
    end

    always_comb begin
        last_d   = gnt_any ? gnt_idx : last_q;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // A drop in the same cycle as a clear is counted after the clear.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (wr_stat && csr_di[16]) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_d != 8'hFF) begin
                drop_d = drop_d + 8'd1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (csr_a[1:0])
            REG_CTRL: begin
                rdata[NCHAN-1:0] = en_q;
                rdata[8]         = irq_en_q;
            end
            REG_STAT: begin
                rdata[DEPTH_LOG2:0] = level_q;
                rdata[16]           = ovf_q;
                rdata[17]           = empty;
                rdata[31:24]        = drop_q;
            end
            REG_META: begin
                rdata[31]   = ~empty;
                rdata[10:8] = empty ? 3'd0 : head[ENT_W-1 -: 3];
                rdata[0]    = ~empty & head[TS_W];
            end
            default: begin
                rdata[TS_W-1:0] = empty ? '0 : head[TS_W-1:0];
            end
        endcase
    end

    assign csr_do_d = page_sel ? rdata : 32'd0;
    assign irq_d    = irq_en_q & ~empty;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            en_q     <= '0;
            irq_en_q <= 1'b0;
            last_q   <= LAST_RST;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            csr_do_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            csr_do_q <= csr_do_d;
            irq_q    <= irq_d;
        end
    end

    // Storage is not reset; level and pointers alone define what is valid.
    always_ff @(posedge sys_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {gnt_idx, pol_sel, ts_sel};
        end
    end

    assign csr_do = csr_do_q;
    assign irq    = irq_q;

    assign unused_ok = ^{csr_a[9:2], csr_di};

endmodule

// File: tb/tb_tdc_event_arbiter.sv
// Directed bench for tdc_event_arbiter: single event path, round-robin order,
// overflow and clear, full push+pop, disabled flush and mid-fill reset.
module tb_tdc_event_arbiter;

    localparam int NCHAN = 2;
    localparam int TS_W  = 32;

    localparam logic [13:0] A_CTRL = 14'h0800;
    localparam logic [13:0] A_STAT = 14'h0801;
    localparam logic [13:0] A_META = 14'h0802;
    localparam logic [13:0] A_TS   = 14'h0803;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst_n = 1'b0;
    logic [NCHAN-1:0]      ev_valid = '0;
    logic [NCHAN-1:0]      ev_pol = '0;
    logic [NCHAN*TS_W-1:0] ev_ts = '0;
    logic [NCHAN-1:0]      ev_ack;
    logic [13:0]           csr_a = '0;
    logic                  csr_we = 1'b0;
    logic [31:0]           csr_di = '0;
    logic [31:0]           csr_do;
    logic                  irq;

    int n_tests = 0;
    int n_fail  = 0;

    tdc_event_arbiter #(
        .NCHAN(NCHAN), .TS_W(TS_W), .DEPTH_LOG2(4), .CSR_ADDR(4'h2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .ev_valid_i(ev_valid),
        .ev_pol_i  (ev_pol),
        .ev_ts_i   (ev_ts),
        .ev_ack_o  (ev_ack),
        .csr_a     (csr_a),
        .csr_we    (csr_we),
        .csr_di    (csr_di),
        .csr_do    (csr_do),
        .irq       (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 ns after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic csr_read(input logic [13:0] a, output logic [31:0] d);
        csr_a  = a;
        csr_we = 1'b0;
        idle(1);
        d = csr_do;
    endtask

    task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        idle(1);
        csr_we = 1'b0;
        csr_di = '0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] ts0, ts1;

        // Reset state
        idle(2);
        check("rst_csr_do", csr_do, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        sys_rst_n = 1'b1;
        idle(1);
        csr_read(A_CTRL, rd);
        check("rst_ctrl", rd, 32'h0);

        // Single event on ch0
        csr_write(A_CTRL, 32'h0000_0101);
        ev_valid = 2'b01;
        ev_pol   = 2'b01;
        ev_ts    = {32'h0, 32'h1234_5678};
        @(negedge sys_clk);
        check("t1_ack", {30'b0, ev_ack}, 32'h1);
        @(posedge sys_clk);
        #1;
        ev_valid = '0;
        check("t1_irq_n1", {31'b0, irq}, 32'h0);
        csr_read(A_STAT, rd);
        check("t1_level", rd, 32'h0000_0001);
        check("t1_irq_n2", {31'b0, irq}, 32'h1);
        csr_read(A_META, rd);
        check("t1_meta", rd, 32'h8000_0001);
        csr_read(A_TS, rd);
        check("t1_ts", rd, 32'h1234_5678);
        csr_read(A_TS, rd);
        check("t1_ts_again", rd, 32'h1234_5678);
        csr_write(A_TS, 32'h0);
        csr_read(A_STAT, rd);
        check("t1_empty", rd, 32'h0002_0000);
        check("t1_irq_drop", {31'b0, irq}, 32'h0);

        // Round-robin from reset: ch0 first
        sys_rst_n = 1'b0;
        idle(1);
        sys_rst_n = 1'b1;
        idle(1);
        csr_write(A_CTRL, 32'h0000_0003);
        for (int i = 0; i < 6; i++) begin
            ev_valid = 2'b11;
            ev_pol   = 2'b10;
            ts0 = 32'h100 + i;
            ts1 = 32'h200 + i;
            ev_ts = {ts1, ts0};
            @(negedge sys_clk);
            check($sformatf("rr_ack%0d", i), {30'b0, ev_ack}, (i % 2 == 0) ? 32'h1 : 32'h2);
            @(posedge sys_clk);
            #1;
        end
        ev_valid = '0;
        csr_read(A_STAT, rd);
        check("rr_level", rd, 32'h0000_0006);
        for (int i = 0; i < 6; i++) begin
            csr_read(A_META, rd);
            check($sformatf("rr_meta%0d", i), rd, (i % 2 == 0) ? 32'h8000_0000 : 32'h8000_0101);
            csr_read(A_TS, rd);
            check($sformatf("rr_ts%0d", i), rd, (i % 2 == 0) ? 32'h100 + i : 32'h200 + i);
            csr_write(A_TS, 32'h0);
        end

        // Fill 16 then 3 more: all acked, 3 dropped
        csr_write(A_CTRL, 32'h0000_0001);
        for (int i = 0; i < 19; i++) begin
            ev_valid = 2'b01;
            ev_pol   = 2'b00;
            ts0 = i;
            ev_ts = {32'h0, ts0};
            @(negedge sys_clk);
            check($sformatf("fill_ack%0d", i), {30'b0, ev_ack}, 32'h1);
            @(posedge sys_clk);
            #1;
        end
        ev_valid = '0;
        csr_read(A_STAT, rd);
        check("ovf_status", rd, 32'h0301_0010);
        csr_read(A_TS, rd);
        check("ovf_head_ts", rd, 32'h0);
        csr_write(A_STAT, 32'h0001_0000);
        csr_read(A_STAT, rd);
        check("ovf_cleared", rd, 32'h0000_0010);

        // Full: push and pop in the same cycle
        ev_valid = 2'b01;
        ev_ts    = {32'h0, 32'h0000_BEEF};
        csr_a    = A_TS;
        csr_we   = 1'b1;
        @(negedge sys_clk);
        check("pp_ack", {30'b0, ev_ack}, 32'h1);
        @(posedge sys_clk);
        #1;
        ev_valid = '0;
        csr_we   = 1'b0;
        csr_read(A_STAT, rd);
        check("pp_status", rd, 32'h0000_0010);
        for (int k = 1; k < 16; k++) begin
            csr_read(A_TS, rd);
            check($sformatf("pp_ts%0d", k), rd, k);
            csr_write(A_TS, 32'h0);
        end
        csr_read(A_TS, rd);
        check("pp_tail", rd, 32'h0000_BEEF);
        csr_read(A_STAT, rd);
        check("pp_last_level", rd, 32'h0000_0001);
        csr_write(A_TS, 32'h0);
        csr_write(A_TS, 32'h0);
        csr_read(A_STAT, rd);
        check("pp_pop_empty", rd, 32'h0002_0000);

        // Disabled channels are flushed
        csr_write(A_CTRL, 32'h0);
        ev_valid = 2'b10;
        @(negedge sys_clk);
        check("dis_ack", {30'b0, ev_ack}, 32'h2);
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        check("dis_ack2", {30'b0, ev_ack}, 32'h2);
        @(posedge sys_clk);
        #1;
        ev_valid = '0;
        csr_read(A_STAT, rd);
        check("dis_status", rd, 32'h0002_0000);
        csr_read(14'h0001, rd);
        check("other_page", rd, 32'h0);

        // Reset mid-fill
        csr_write(A_CTRL, 32'h0000_0101);
        for (int i = 0; i < 5; i++) begin
            ev_valid = 2'b01;
            ts0 = 32'h50 + i;
            ev_ts = {32'h0, ts0};
            idle(1);
        end
        ev_valid = '0;
        csr_read(A_STAT, rd);
        check("mid_level", rd, 32'h0000_0005);
        check("mid_irq", {31'b0, irq}, 32'h1);
        #2;
        ev_valid  = 2'b01;
        sys_rst_n = 1'b0;
        #1;
        check("mr_csr_do", csr_do, 32'h0);
        check("mr_irq", {31'b0, irq}, 32'h0);
        check("mr_ack", {30'b0, ev_ack}, 32'h1);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        ev_valid  = '0;
        csr_read(A_STAT, rd);
        check("mr_status", rd, 32'h0002_0000);
        csr_read(A_CTRL, rd);
        check("mr_ctrl", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_event_arbiter.md
# tdc_event_arbiter

Round-robin merger that shares one timestamp FIFO and one CSR read port among NCHAN TDC channel event streams. It sits between the per-channel serdes TDC cores and the CSR bus, in the sys_clk domain. Each accepted event is tagged with its channel number and edge polarity. The CPU drains events through CSR reads and receives a level interrupt while the FIFO is non-empty.

## Interface
- NCHAN, 2: number of TDC channels, 1..8.
- TS_W, 32: timestamp width, ≤32.
- DEPTH_LOG2, 4: FIFO depth exponent; depth = 16.
- CSR_ADDR, 4'h2: CSR page, matched against csr_a[13:10].

Ports:
- sys_clk  in  1  system clock; the block has one clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- ev_valid_i  in  NCHAN  per-channel event pending.
- ev_pol_i  in  NCHAN  per-channel edge polarity (1 = rising).
- ev_ts_i  in  NCHAN*TS_W  per-channel timestamp; channel k occupies bits [k*TS_W +: TS_W].
- ev_ack_o  out  NCHAN  per-channel accept strobe (combinational).
- csr_a  in  14  CSR address.
- csr_we  in  1  CSR write strobe.
- csr_di  in  32  CSR write data.
- csr_do  out  32  CSR read data, registered. Drives 0 when the page is not selected, so it can be OR-combined on the bus.
- irq  out  1  level interrupt.

## Operation
- Registers are selected by csr_a[1:0] when csr_a[13:10]==CSR_ADDR.
  - 0 CTRL (R/W): [7:0] channel enable mask (bits ≥NCHAN read 0); [8] irq_en.
  - 1 STATUS: [DEPTH_LOG2:0] level; [16] overflow, sticky, cleared by writing 1 to bit 16; [17] empty; [31:24] drop count, saturating at 255, cleared with bit 16.
  - 2 HEAD_META (RO): [31] valid (non-empty); [10:8] channel; [0] polarity. Reads have no side effect.
  - 3 HEAD_TS: a read returns the head timestamp, zero-extended. Any write pops one entry; a write when empty is ignored. Reads never pop, so repeated reads are idempotent.
- Arbitration:
  - The candidate set is channels with ev_valid_i & enable.
  - Round-robin: search starts at (last_grant+1) mod NCHAN. At most one grant per cycle.
  - ev_ack_o[g]=1 in the same cycle for the granted channel. The event transfers on valid & ack.
  - last_grant updates only on a grant.
- Disabled channels: ev_ack_o[k]=ev_valid_i[k] every cycle, so the event is flushed and not recorded. No overflow and no drop-count change.
- FIFO entry is {chan[2:0], pol, ts[TS_W-1:0]}.
- Push rule: a push is accepted if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
  - Otherwise the granted event is still acked, discarded, overflow is set, and the drop count increments.
- Simultaneous push and pop: level is unchanged and the head advances. If the FIFO holds one entry, the new event becomes the head.
- Level arithmetic: DEPTH_LOG2+1 bits. Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
- irq = registered (irq_en & ~empty).
- Reset values:
  - Outputs: csr_do=0, irq=0, ev_ack_o follows its combinational equation with CTRL=0.
  - Internal state: level=0, pointers=0, CTRL=0 (all channels disabled, so valid inputs are flushed), overflow=0, drop count=0, last_grant=NCHAN-1 (channel 0 has first priority).
- Reset mid-operation: FIFO contents are lost, and pending events are not acked differently from the rule above.

## Timing
- Event acked in cycle N:
  - Visible in STATUS.level, HEAD_*, and the empty flag in cycle N+1.
  - irq rises at N+2.
- CSR read: csr_do is valid on the clock after csr_a is presented. It is 0 the cycle after a non-matching address.
- CSR write takes effect on the edge where csr_we=1. A pop at edge M makes the new head readable from M+1.
- Enable change at edge M affects arbitration from cycle M+1.
- Throughput: 1 event/cycle aggregate. With K channels continuously valid, each is granted once every K cycles.

## Test plan
- Enable ch0 only; pulse ch0 with ts=0x12345678, pol=1 → ack same cycle. Next cycle: level=1, HEAD_META=0x80000001, HEAD_TS=0x12345678. irq=1 two cycles after the ack if irq_en=1. Write reg3 → level=0, irq drops.
- Both channels enabled and held valid for 6 cycles → grants alternate 0,1,0,1,0,1 starting with ch0 after reset. FIFO order and channel tags match.
- Fill with 16 events, then present 3 more → all acked, level=16, overflow=1, drop count=3. Write 0x10000 to STATUS → overflow=0, count=0.
- At level=16, push and pop in the same cycle → level stays 16, no overflow, new entry stored at the tail.
- CTRL=0 with ch1 valid → ev_ack_o[1]=1, level stays 0. Assert sys_rst_n=0 mid-fill (level=5) → level=0, csr_do=0, irq=0 immediately, CTRL reads 0 after release.
